// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write-port arbiter: grant encoding,
// the default-width queue entry layout and the starvation counter width.
package regfile_arb_pkg;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_A    = 2'd1,
      GNT_B    = 2'd2
   } grant_e;

   // Starvation counter width; STARVE_LIMIT must fit (<= 255).
   localparam int STARVE_CNT_W = 8;

   localparam int DEF_ADDRESS_WIDTH = 5;
   localparam int DEF_DATA_WIDTH    = 32;

   // Queue entry layout at the default widths; wb_fifo keeps the same field
   // order with its parameterised widths.
   typedef struct packed {
      logic                         valid;
      logic [DEF_ADDRESS_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0]    data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small queue of pending long-latency writebacks with per-entry
// invalidate-by-address and youngest-match forwarding for two read ports.
module wb_fifo #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_push_valid,
   input  logic [ADDRESS_WIDTH-1:0] i_push_addr,
   input  logic [DATA_WIDTH-1:0]    i_push_data,
   input  logic                     i_pop,
   input  logic                     i_inv_en,
   input  logic [ADDRESS_WIDTH-1:0] i_inv_addr,
   input  logic [ADDRESS_WIDTH-1:0] i_rd1_addr,
   input  logic [ADDRESS_WIDTH-1:0] i_rd2_addr,
   output logic                     o_empty,
   output logic                     o_full,
   output logic                     o_head_valid,
   output logic [ADDRESS_WIDTH-1:0] o_head_addr,
   output logic [DATA_WIDTH-1:0]    o_head_data,
   output logic                     o_fwd1_hit,
   output logic [DATA_WIDTH-1:0]    o_fwd1_data,
   output logic                     o_fwd2_hit,
   output logic [DATA_WIDTH-1:0]    o_fwd2_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic                     valid;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    data;
   } entry_t;

   entry_t           r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic [DATA_WIDTH:0] w_fwd1;
   logic [DATA_WIDTH:0] w_fwd2;

   // A valid bit implies the slot is occupied: pops clear it, so the
   // forwarding search only needs to walk from head toward tail.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i].valid <= 1'b0;
         end
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (i_inv_en && r_mem[i].valid && (r_mem[i].addr == i_inv_addr)) begin
               r_mem[i].valid <= 1'b0;
            end
         end
         if (i_pop) begin
            r_mem[r_rd_ptr].valid <= 1'b0;
            r_rd_ptr              <= r_rd_ptr + 1'b1;
         end
         if (i_push) begin
            r_mem[r_wr_ptr].valid <= i_push_valid;
            r_mem[r_wr_ptr].addr  <= i_push_addr;
            r_mem[r_wr_ptr].data  <= i_push_data;
            r_wr_ptr              <= r_wr_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Walk oldest to youngest so the last match found is the youngest.
   function automatic logic [DATA_WIDTH:0] youngest_match(input logic [ADDRESS_WIDTH-1:0] rd);
      logic [PTR_W-1:0] idx;
      youngest_match = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         idx = r_rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < r_count) && r_mem[idx].valid &&
             (r_mem[idx].addr == rd) && (rd != '0)) begin
            youngest_match = {1'b1, r_mem[idx].data};
         end
      end
   endfunction

   always_comb begin
      o_empty      = (r_count == '0);
      o_full       = (r_count == DEPTH_C);
      o_head_valid = r_mem[r_rd_ptr].valid && !o_empty;
      o_head_addr  = r_mem[r_rd_ptr].addr;
      o_head_data  = r_mem[r_rd_ptr].data;
      w_fwd1       = youngest_match(i_rd1_addr);
      w_fwd2       = youngest_match(i_rd2_addr);
      o_fwd1_hit   = w_fwd1[DATA_WIDTH];
      o_fwd1_data  = w_fwd1[DATA_WIDTH-1:0];
      o_fwd2_hit   = w_fwd2[DATA_WIDTH];
      o_fwd2_data  = w_fwd2[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the in-order pipeline (A,
// priority) and a queued long-latency unit (B) with a starvation stall.
module regfile_wb_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     a_we_i,
   input  logic [ADDRESS_WIDTH-1:0] a_addr_i,
   input  logic [DATA_WIDTH-1:0]    a_wd_i,
   input  logic                     b_valid_i,
   output logic                     b_ready_o,
   input  logic [ADDRESS_WIDTH-1:0] b_addr_i,
   input  logic [DATA_WIDTH-1:0]    b_wd_i,
   output logic                     stall_o,
   output logic                     rf_we_o,
   output logic [ADDRESS_WIDTH-1:0] rf_addr_o,
   output logic [DATA_WIDTH-1:0]    rf_wd_o,
   input  logic [ADDRESS_WIDTH-1:0] rd1_addr_i,
   input  logic [ADDRESS_WIDTH-1:0] rd2_addr_i,
   output logic                     fwd1_hit_o,
   output logic                     fwd2_hit_o,
   output logic [DATA_WIDTH-1:0]    fwd1_data_o,
   output logic [DATA_WIDTH-1:0]    fwd2_data_o,
   output logic                     busy_o
);

   localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] r_starve_cnt;

   grant_e                  w_grant;
   logic                    w_a_eff;
   logic                    w_head_ok;
   logic                    w_stall;
   logic                    w_push;
   logic                    w_push_valid;
   logic                    w_pop;
   logic                    w_inv_en;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_head_valid;
   logic [ADDRESS_WIDTH-1:0] w_head_addr;
   logic [DATA_WIDTH-1:0]   w_head_data;
   logic                    w_fwd1_hit;
   logic                    w_fwd2_hit;
   logic [DATA_WIDTH-1:0]   w_fwd1_data;
   logic [DATA_WIDTH-1:0]   w_fwd2_data;

   wb_fifo #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .FIFO_DEPTH    (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push),
      .i_push_valid (w_push_valid),
      .i_push_addr  (b_addr_i),
      .i_push_data  (b_wd_i),
      .i_pop        (w_pop),
      .i_inv_en     (w_inv_en),
      .i_inv_addr   (a_addr_i),
      .i_rd1_addr   (rd1_addr_i),
      .i_rd2_addr   (rd2_addr_i),
      .o_empty      (w_empty),
      .o_full       (w_full),
      .o_head_valid (w_head_valid),
      .o_head_addr  (w_head_addr),
      .o_head_data  (w_head_data),
      .o_fwd1_hit   (w_fwd1_hit),
      .o_fwd1_data  (w_fwd1_data),
      .o_fwd2_hit   (w_fwd2_hit),
      .o_fwd2_data  (w_fwd2_data)
   );

   always_comb begin
      w_a_eff   = a_we_i && (a_addr_i != '0);
      w_head_ok = !w_empty && w_head_valid;
      w_stall   = (r_starve_cnt == STARVE_MAX) && w_head_ok && w_a_eff;

      w_grant = GNT_NONE;
      if (rst) begin
         w_grant = GNT_NONE;
      end else if (w_stall) begin
         w_grant = GNT_B;
      end else if (w_a_eff) begin
         w_grant = GNT_A;
      end else if (w_head_ok) begin
         w_grant = GNT_B;
      end

      rf_we_o   = 1'b0;
      rf_addr_o = '0;
      rf_wd_o   = '0;
      case (w_grant)
         GNT_A: begin
            rf_we_o   = 1'b1;
            rf_addr_o = a_addr_i;
            rf_wd_o   = a_wd_i;
         end
         GNT_B: begin
            rf_we_o   = 1'b1;
            rf_addr_o = w_head_addr;
            rf_wd_o   = w_head_data;
         end
         default: ;
      endcase

      stall_o   = !rst && w_stall;
      // An invalidated head is discarded without using the write port.
      w_pop     = (w_grant == GNT_B) || (!rst && !w_empty && !w_head_valid);
      b_ready_o = !rst && !w_full;
      w_push    = b_valid_i && b_ready_o;
      // A same-cycle A write to the same register is younger, so B's value is dead.
      w_push_valid = (b_addr_i != '0) && !((w_grant == GNT_A) && (a_addr_i == b_addr_i));
      w_inv_en  = (w_grant == GNT_A);
      busy_o    = !rst && !w_empty;

      fwd1_hit_o  = !rst && w_fwd1_hit;
      fwd2_hit_o  = !rst && w_fwd2_hit;
      fwd1_data_o = rst ? '0 : w_fwd1_data;
      fwd2_data_o = rst ? '0 : w_fwd2_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (w_pop || w_empty) begin
         r_starve_cnt <= '0;
      end else if (w_head_ok && (w_grant != GNT_B) && (r_starve_cnt != STARVE_MAX)) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: register-file writes are checked by a monitor against an
// expected queue of {stall, addr, data}; side outputs are checked inline.
module tb_regfile_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int W  = 1 + AW + DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_we_i;
   logic [AW-1:0] a_addr_i;
   logic [DW-1:0] a_wd_i;
   logic          b_valid_i;
   logic          b_ready_o;
   logic [AW-1:0] b_addr_i;
   logic [DW-1:0] b_wd_i;
   logic          stall_o;
   logic          rf_we_o;
   logic [AW-1:0] rf_addr_o;
   logic [DW-1:0] rf_wd_o;
   logic [AW-1:0] rd1_addr_i;
   logic [AW-1:0] rd2_addr_i;
   logic          fwd1_hit_o;
   logic          fwd2_hit_o;
   logic [DW-1:0] fwd1_data_o;
   logic [DW-1:0] fwd2_data_o;
   logic          busy_o;

   logic [W-1:0] exp_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;

   regfile_wb_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .a_we_i      (a_we_i),
      .a_addr_i    (a_addr_i),
      .a_wd_i      (a_wd_i),
      .b_valid_i   (b_valid_i),
      .b_ready_o   (b_ready_o),
      .b_addr_i    (b_addr_i),
      .b_wd_i      (b_wd_i),
      .stall_o     (stall_o),
      .rf_we_o     (rf_we_o),
      .rf_addr_o   (rf_addr_o),
      .rf_wd_o     (rf_wd_o),
      .rd1_addr_i  (rd1_addr_i),
      .rd2_addr_i  (rd2_addr_i),
      .fwd1_hit_o  (fwd1_hit_o),
      .fwd2_hit_o  (fwd2_hit_o),
      .fwd1_data_o (fwd1_data_o),
      .fwd2_data_o (fwd2_data_o),
      .busy_o      (busy_o)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required end of stimulus");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drv_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      a_we_i   = we;
      a_addr_i = addr;
      a_wd_i   = wd;
   endtask

   task automatic drv_b(input logic v, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      b_valid_i = v;
      b_addr_i  = addr;
      b_wd_i    = wd;
   endtask

   task automatic exp_wr(input logic st, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      exp_q.push_back({st, addr, wd});
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [W-1:0] got;
      logic [W-1:0] want;
      if (rf_we_o === 1'b1) begin
         n_checks++;
         got = {stall_o, rf_addr_o, rf_wd_o};
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rf_write_unexpected: got stall=%0b addr=%0d data=0x%0h, required no write",
                     stall_o, rf_addr_o, rf_wd_o);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               n_fail++;
               $display("FAIL rf_write: got stall=%0b addr=%0d data=0x%0h, required stall=%0b addr=%0d data=0x%0h",
                        got[W-1], got[W-2 -: AW], got[DW-1:0],
                        want[W-1], want[W-2 -: AW], want[DW-1:0]);
            end
         end
      end
   end

   // Stimulus
   initial begin
      rst = 1'b1;
      drv_a(1'b0, '0, '0);
      drv_b(1'b0, '0, '0);
      rd1_addr_i = '0;
      rd2_addr_i = '0;
      tick();
      tick();
      mid();
      chk("reset_b_ready", 64'(b_ready_o), 64'd0);
      chk("reset_busy", 64'(busy_o), 64'd0);
      chk("reset_rf_we", 64'(rf_we_o), 64'd0);
      chk("reset_stall", 64'(stall_o), 64'd0);
      chk("reset_fwd1_hit", 64'(fwd1_hit_o), 64'd0);

      // Single B push with A idle drains the next cycle
      tick(); rst = 1'b0;
      drv_b(1'b1, 5'd5, 32'hAAAA);
      mid();
      chk("t1_b_ready", 64'(b_ready_o), 64'd1);
      chk("t1_busy_before", 64'(busy_o), 64'd0);
      tick(); drv_b(1'b0, '0, '0);
      exp_wr(1'b0, 5'd5, 32'hAAAA);
      mid();
      chk("t1_busy_draining", 64'(busy_o), 64'd1);
      tick(); mid();
      chk("t1_busy_after", 64'(busy_o), 64'd0);

      // A writes x3 every cycle; queued x7 is forced out by the stall
      tick();
      drv_a(1'b1, 5'd3, 32'h300);
      drv_b(1'b1, 5'd7, 32'h77);
      exp_wr(1'b0, 5'd3, 32'h300);
      mid();
      for (int k = 1; k <= 4; k++) begin
         tick();
         drv_b(1'b0, '0, '0);
         drv_a(1'b1, 5'd3, 32'h300 + 32'(k));
         exp_wr(1'b0, 5'd3, 32'h300 + 32'(k));
         mid();
         chk("t2_no_stall_yet", 64'(stall_o), 64'd0);
      end
      tick();
      drv_a(1'b1, 5'd3, 32'h305);
      exp_wr(1'b1, 5'd7, 32'h77);
      mid();
      chk("t2_stall", 64'(stall_o), 64'd1);
      tick();
      drv_a(1'b1, 5'd3, 32'h306);
      exp_wr(1'b0, 5'd3, 32'h306);
      mid();
      chk("t2_stall_released", 64'(stall_o), 64'd0);
      chk("t2_busy_empty", 64'(busy_o), 64'd0);

      // Fill the FIFO behind A, then forward; youngest match wins
      tick();
      drv_a(1'b1, 5'd10, 32'h100);
      drv_b(1'b1, 5'd8, 32'd1);
      exp_wr(1'b0, 5'd10, 32'h100);
      mid();
      tick();
      drv_a(1'b1, 5'd10, 32'h101);
      drv_b(1'b1, 5'd9, 32'd2);
      exp_wr(1'b0, 5'd10, 32'h101);
      mid();
      chk("t3_ready_one_free", 64'(b_ready_o), 64'd1);
      tick();
      drv_a(1'b1, 5'd10, 32'h102);
      drv_b(1'b0, '0, '0);
      rd1_addr_i = 5'd9;
      rd2_addr_i = 5'd8;
      exp_wr(1'b0, 5'd10, 32'h102);
      mid();
      chk("t3_full_ready", 64'(b_ready_o), 64'd0);
      chk("t3_fwd1_hit", 64'(fwd1_hit_o), 64'd1);
      chk("t3_fwd1_data", 64'(fwd1_data_o), 64'd2);
      chk("t3_fwd2_hit", 64'(fwd2_hit_o), 64'd1);
      chk("t3_fwd2_data", 64'(fwd2_data_o), 64'd1);
      tick(); drv_a(1'b0, '0, '0);
      exp_wr(1'b0, 5'd8, 32'd1);
      mid();
      tick();
      exp_wr(1'b0, 5'd9, 32'd2);
      mid();
      tick();
      drv_a(1'b1, 5'd11, 32'h110);
      drv_b(1'b1, 5'd8, 32'd1);
      exp_wr(1'b0, 5'd11, 32'h110);
      mid();
      tick();
      drv_a(1'b1, 5'd11, 32'h111);
      drv_b(1'b1, 5'd8, 32'd4);
      exp_wr(1'b0, 5'd11, 32'h111);
      mid();
      tick();
      drv_a(1'b1, 5'd11, 32'h112);
      drv_b(1'b0, '0, '0);
      rd1_addr_i = 5'd8;
      rd2_addr_i = 5'd0;
      exp_wr(1'b0, 5'd11, 32'h112);
      mid();
      chk("t3_youngest_hit", 64'(fwd1_hit_o), 64'd1);
      chk("t3_youngest_data", 64'(fwd1_data_o), 64'd4);
      chk("t3_rd_x0_no_hit", 64'(fwd2_hit_o), 64'd0);
      tick(); drv_a(1'b0, '0, '0);
      exp_wr(1'b0, 5'd8, 32'd1);
      mid();
      tick();
      exp_wr(1'b0, 5'd8, 32'd4);
      mid();

      // WAW: A overwrites a queued register; the stale entry pops silently
      tick();
      rd1_addr_i = '0;
      drv_a(1'b1, 5'd12, 32'h120);
      drv_b(1'b1, 5'd6, 32'h11);
      exp_wr(1'b0, 5'd12, 32'h120);
      mid();
      tick();
      drv_b(1'b0, '0, '0);
      drv_a(1'b1, 5'd6, 32'h22);
      exp_wr(1'b0, 5'd6, 32'h22);
      mid();
      tick();
      drv_a(1'b0, '0, '0);
      rd1_addr_i = 5'd6;
      mid();
      chk("t4_busy_stale", 64'(busy_o), 64'd1);
      chk("t4_stale_no_write", 64'(rf_we_o), 64'd0);
      chk("t4_stale_no_fwd", 64'(fwd1_hit_o), 64'd0);
      tick(); rd1_addr_i = '0;
      mid();
      chk("t4_busy_after", 64'(busy_o), 64'd0);

      // Writes to x0 from both sides never reach the register file
      tick();
      drv_a(1'b1, 5'd0, 32'h55);
      drv_b(1'b1, 5'd0, 32'h66);
      mid();
      chk("t5_b_ready", 64'(b_ready_o), 64'd1);
      chk("t5_no_write_a0", 64'(rf_we_o), 64'd0);
      tick();
      drv_b(1'b0, '0, '0);
      drv_a(1'b1, 5'd0, 32'h56);
      mid();
      chk("t5_busy_slot", 64'(busy_o), 64'd1);
      chk("t5_no_stall", 64'(stall_o), 64'd0);
      chk("t5_no_write_pop", 64'(rf_we_o), 64'd0);
      tick(); drv_a(1'b0, '0, '0);
      mid();
      chk("t5_busy_after", 64'(busy_o), 64'd0);

      // Push and pop in the same cycle
      tick();
      drv_b(1'b1, 5'd20, 32'h20);
      mid();
      tick();
      drv_b(1'b1, 5'd21, 32'h21);
      exp_wr(1'b0, 5'd20, 32'h20);
      mid();
      chk("t7_ready_push_pop", 64'(b_ready_o), 64'd1);
      tick();
      drv_b(1'b0, '0, '0);
      exp_wr(1'b0, 5'd21, 32'h21);
      mid();
      chk("t7_busy_one_left", 64'(busy_o), 64'd1);
      tick(); mid();
      chk("t7_busy_after", 64'(busy_o), 64'd0);

      // Reset with two queued entries drops them
      tick();
      drv_a(1'b1, 5'd13, 32'h130);
      drv_b(1'b1, 5'd14, 32'hE);
      exp_wr(1'b0, 5'd13, 32'h130);
      mid();
      tick();
      drv_a(1'b1, 5'd13, 32'h131);
      drv_b(1'b1, 5'd15, 32'hF);
      exp_wr(1'b0, 5'd13, 32'h131);
      mid();
      tick();
      rst = 1'b1;
      drv_a(1'b0, '0, '0);
      drv_b(1'b0, '0, '0);
      rd1_addr_i = 5'd14;
      rd2_addr_i = 5'd15;
      mid();
      chk("t6_rst_busy", 64'(busy_o), 64'd0);
      chk("t6_rst_fwd1", 64'(fwd1_hit_o), 64'd0);
      chk("t6_rst_fwd1_data", 64'(fwd1_data_o), 64'd0);
      chk("t6_rst_b_ready", 64'(b_ready_o), 64'd0);
      tick();
      rst = 1'b0;
      mid();
      chk("t6_post_busy", 64'(busy_o), 64'd0);
      chk("t6_post_fwd1", 64'(fwd1_hit_o), 64'd0);
      chk("t6_post_fwd2", 64'(fwd2_hit_o), 64'd0);
      chk("t6_post_b_ready", 64'(b_ready_o), 64'd1);
      tick(); mid();
      tick(); mid();

      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

      // Final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
